// File: rtl/img_edge_pkg.sv
// Shared types and default geometry for the edge-detector readout path.
package img_edge_pkg;

    localparam int IMG_W_DEF = 5;
    localparam int IMG_H_DEF = 5;
    localparam int PXL_W_DEF = 8;

    typedef logic [PXL_W_DEF-1:0] pxl_t;

    // One output beat: pixel plus its frame position markers.
    typedef struct packed {
        pxl_t data;
        logic sof;
        logic eol;
        logic eof;
    } stream_beat_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN
    } fos_state_e;

endpackage

// File: rtl/frame_out_streamer_beat_fifo2.sv
// Two-entry registered FIFO of stream beats; head entry is a register so it
// can drive the stream outputs directly. Push and pop may share a cycle.
module beat_fifo2
    import img_edge_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  stream_beat_t din,
    output stream_beat_t head,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    stream_beat_t tail;
    logic         do_pop;

    assign empty  = (count == 2'd0);
    assign full   = (count == 2'd2);
    assign do_pop = pop && !empty;

    // Shift-style storage: head always holds the oldest entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (empty) head <= din;
                    else       tail <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; with one entry the new beat becomes head.
                    if (count == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/frame_out_streamer.sv
// Reads the processed frame out of the output frame buffer in raster order
// and streams it with valid/ready plus sof/eol/eof markers.
module frame_out_streamer
    import img_edge_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int PXL_W = PXL_W_DEF,
    parameter int X_W   = $clog2(IMG_W),
    parameter int Y_W   = $clog2(IMG_H)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_buf_out_rd_en,
    output logic [X_W-1:0]   frame_buf_out_rd_x,
    output logic [Y_W-1:0]   frame_buf_out_rd_y,
    input  logic [PXL_W-1:0] frame_buf_out_rd_data_pxl,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PXL_W-1:0] m_data,
    output logic             m_sof,
    output logic             m_eol,
    output logic             m_eof
);

    fos_state_e   state;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic         inflight;
    logic         sof_q, eol_q, eof_q;
    logic         rd_en, pop, x_last, y_last;
    stream_beat_t wbeat, head;
    logic [1:0]   fifo_count;
    logic         fifo_full, fifo_empty;

    assign x_last = (x == X_W'(IMG_W - 1));
    assign y_last = (y == Y_W'(IMG_H - 1));

    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;

    // Issue a read only if the FIFO can still hold it once every outstanding
    // read has landed; a same-cycle pop frees one slot.
    assign rd_en = (state == ST_STREAM) &&
                   (({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_DRAIN) && pop && head.eof;

    assign frame_buf_out_rd_en = rd_en;
    assign frame_buf_out_rd_x  = x;
    assign frame_buf_out_rd_y  = y;

    assign m_data = head.data;
    assign m_sof  = head.sof;
    assign m_eol  = head.eol;
    assign m_eof  = head.eof;

    // Read-side FSM and raster counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            x     <= '0;
            y     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x     <= '0;
                        y     <= '0;
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (rd_en) begin
                        if (x_last) begin
                            x <= '0;
                            if (y_last) begin
                                y     <= '0;
                                state <= ST_DRAIN;
                            end else begin
                                y <= y + Y_W'(1);
                            end
                        end else begin
                            x <= x + X_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (frame_done) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Position tags travel alongside the read so they line up with the data
    // that returns one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            sof_q    <= 1'b0;
            eol_q    <= 1'b0;
            eof_q    <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (rd_en) begin
                sof_q <= (x == '0) && (y == '0);
                eol_q <= x_last;
                eof_q <= x_last && y_last;
            end
        end
    end

    // Returning read data joined with its tags forms the FIFO write beat.
    always_comb begin
        wbeat      = '0;
        wbeat.data = frame_buf_out_rd_data_pxl;
        wbeat.sof  = sof_q;
        wbeat.eol  = eol_q;
        wbeat.eof  = eof_q;
    end

    beat_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (pop),
        .din   (wbeat),
        .head  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Read throttling guarantees a landing slot for every in-flight read.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(inflight && fifo_full && !pop));

endmodule

// File: tb/tb_frame_out_streamer.sv
// Directed bench for frame_out_streamer with a behavioural frame buffer.
module tb_frame_out_streamer;
    import img_edge_pkg::*;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int PW = 8;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          m_ready = 1'b0;
    logic          busy, frame_done, rd_en, m_valid, m_sof, m_eol, m_eof;
    logic [2:0]    rd_x, rd_y;
    logic [PW-1:0] rd_data = '0;
    logic [PW-1:0] m_data;

    frame_out_streamer dut (
        .clk                       (clk),
        .rst                       (rst),
        .start                     (start),
        .busy                      (busy),
        .frame_done                (frame_done),
        .frame_buf_out_rd_en       (rd_en),
        .frame_buf_out_rd_x        (rd_x),
        .frame_buf_out_rd_y        (rd_y),
        .frame_buf_out_rd_data_pxl (rd_data),
        .m_valid                   (m_valid),
        .m_ready                   (m_ready),
        .m_data                    (m_data),
        .m_sof                     (m_sof),
        .m_eol                     (m_eol),
        .m_eof                     (m_eof)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, t0 = 0, img_mode = 0;
    int k, beats, done_cnt, rd_cnt, acc, first_cyc, last_cyc, third_x, third_y;
    logic        stall_q = 1'b0;
    logic [11:0] hold_q = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // mode 0: diagonal 250..254, else 0; mode 1: ramp 10 + raster index
    function automatic logic [7:0] pix(input int x, input int y);
        if (img_mode == 0) return (x == y) ? 8'(250 + x) : 8'd0;
        return 8'(10 + y * W + x);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_data <= pix(int'(rd_x), int'(rd_y));
    end

    // Beat monitor, sampled mid-cycle.
    always @(negedge clk) begin
        int kk;
        if (!rst) begin
            if (rd_en) begin
                if (rd_cnt == 2) begin
                    third_x = int'(rd_x);
                    third_y = int'(rd_y);
                end
                rd_cnt++;
            end
            if (stall_q) chk("hold", {m_valid, m_sof, m_eol, m_eof, m_data}, hold_q);
            if (m_valid && m_ready) begin
                kk = k % N;
                chk("data", m_data, pix(kk % W, kk / W));
                chk("sof", m_sof, kk == 0);
                chk("eol", m_eol, (kk % W) == W - 1);
                chk("eof", m_eof, kk == N - 1);
                chk("done_hs", frame_done, kk == N - 1);
                if (beats == 0) first_cyc = cyc - t0;
                last_cyc = cyc - t0;
                beats++;
                k++;
                acc++;
            end else begin
                chk("done_idle", frame_done, 0);
            end
            if (frame_done) done_cnt++;
            chk("outst", (rd_cnt - acc) <= 2, 1);
            stall_q = m_valid && !m_ready;
            hold_q  = {m_valid, m_sof, m_eol, m_eof, m_data};
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic new_frame(input int mode);
        img_mode = mode;
        k = 0; beats = 0; done_cnt = 0; rd_cnt = 0; acc = 0;
        first_cyc = -1; last_cyc = -1; third_x = -1; third_y = -1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // rmode 0: hold m_ready; rmode 1: 1,0,0,1 pattern
    task automatic run_until(input int target, input int budget, input int rmode);
        int i;
        for (i = 0; i < budget; i++) begin
            if (done_cnt >= target) break;
            @(posedge clk);
            #1;
            if (rmode == 1) m_ready = ((cyc - t0) % 4 == 0) || ((cyc - t0) % 4 == 3);
        end
        chk("budget", done_cnt >= target, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fd"}, frame_done, 0);
        chk({tag, "_rden"}, rd_en, 0);
        chk({tag, "_rdxy"}, {rd_x, rd_y}, 0);
        chk({tag, "_mvld"}, m_valid, 0);
        chk({tag, "_mdata"}, m_data, 0);
        chk({tag, "_flags"}, {m_sof, m_eol, m_eof}, 0);
    endtask

    initial begin
        new_frame(0);
        tick(3);
        chk_zero("rst");
        rst = 1'b0;
        tick(2);

        // 1: full-rate diagonal frame
        new_frame(0);
        m_ready = 1'b1;
        pulse_start();
        run_until(1, 100, 0);
        chk("t1_busy_after", busy, 0);
        chk("t1_beats", beats, N);
        chk("t1_first", first_cyc, 3);
        chk("t1_last", last_cyc, 3 + N - 1);
        chk("t1_done", done_cnt, 1);

        // 2: ready pattern 1,0,0,1
        tick(2);
        new_frame(0);
        pulse_start();
        run_until(1, 200, 1);
        tick(5);
        chk("t2_beats", beats, N);
        chk("t2_done", done_cnt, 1);

        // 3: consumer stalled for 20 cycles
        m_ready = 1'b0;
        tick(2);
        new_frame(1);
        pulse_start();
        tick(19);
        chk("t3_rdcnt", rd_cnt, 2);
        chk("t3_rden_low", rd_en, 0);
        chk("t3_valid", m_valid, 1);
        m_ready = 1'b1;
        run_until(1, 100, 0);
        chk("t3_third_x", third_x, 2);
        chk("t3_third_y", third_y, 0);
        chk("t3_beats", beats, N);

        // 4: start re-pulsed mid-frame is ignored
        tick(2);
        new_frame(1);
        pulse_start();
        while (cyc - t0 < 10) tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        run_until(1, 100, 0);
        tick(10);
        chk("t4_beats", beats, N);
        chk("t4_done", done_cnt, 1);
        chk("t4_busy", busy, 0);

        // 5: reset mid-frame, then a clean frame
        tick(2);
        new_frame(1);
        pulse_start();
        while (cyc - t0 < 12) tick(1);
        rst = 1'b1;
        tick(1);
        chk_zero("midrst");
        rst = 1'b0;
        tick(2);
        new_frame(1);
        pulse_start();
        run_until(1, 100, 0);
        chk("t5_beats", beats, N);
        chk("t5_first", first_cyc, 3);

        // 6: start held high gives back-to-back frames
        tick(2);
        new_frame(1);
        @(posedge clk);
        #1;
        start = 1'b1;
        t0 = cyc;
        run_until(2, 200, 0);
        start = 1'b0;
        tick(10);
        chk("t6_beats", beats, 2 * N);
        chk("t6_done", done_cnt, 2);
        chk("t6_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
